fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main controller in the MIPS-subset core.
- Owns the PC and drives a variable-latency instruction memory through a req/ack handshake.
- Holds the fetched word stable on `inst` for the controller and datapath.
- Computes the next PC from the controller's `pc_src`/`jump`/`jr` outputs; each instruction takes one fetch phase plus one execute cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- WORD_WIDTH, 32, instruction/address width.

Ports:
- clk  in  1  core clock
- nrst  in  1  synchronous active-low reset
- imem_req  out  1  fetch request, high while waiting for instruction memory
- imem_addr  out  32  fetch address, equals `pc`
- imem_ack  in  1  memory has valid `imem_rdata` this cycle
- imem_rdata  in  32  instruction word from memory
- inst  out  32  current instruction to the controller/datapath
- inst_valid  out  1  `inst` is being executed this cycle
- pc  out  32  address of current instruction
- pc_plus4  out  32  `pc`+4, used as the jal link value
- pc_src  in  1  taken branch, from the controller
- jump  in  1  j/jal, from the controller
- jr  in  1  jr, from the controller
- jr_target  in  32  rs register value for jr
- exec_stall  in  1  hold the current instruction in execute (e.g. data memory busy)
- retired_count  out  32  number of retired instructions

Behaviour:
- One clock (`clk`); reset is synchronous and active-low on `nrst`. Every register updates on the rising edge of `clk`.
- Reset values while `nrst`=0:
  - state=IDLE, `pc`=RESET_PC, `inst`=32'h0000_0000 (NOP), `inst_valid`=0, `imem_req`=0, `retired_count`=0.
- State machine, states IDLE, FETCH, EXEC:
  - IDLE: `imem_req`=0. Unconditionally goes to FETCH next cycle, so the first request appears one cycle after reset release.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`, `inst_valid`=0. `inst` keeps its previous value. When `imem_ack`=1 at a clock edge: `inst` <= `imem_rdata`, go to EXEC. Otherwise stay in FETCH.
  - EXEC: `imem_req`=0, `inst_valid`=1.
    - If `exec_stall`=1: stay in EXEC; `pc`, `inst` and count unchanged.
    - Else: `pc` <= next_pc, `retired_count` <= `retired_count`+1 (wraps at 2^32), go to FETCH.
- Minimum 2 cycles per instruction (1-cycle fetch with immediate ack, plus EXEC).
- next_pc is combinational, evaluated only in EXEC, with priority jr > jump > pc_src > sequential:
  - jr: `jr_target` (no alignment check; low bits passed through).
  - jump: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - pc_src: pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}.
  - default: pc_plus4.
- All additions are 32-bit modulo; wrap-around from 32'hFFFF_FFFC yields 32'h0000_0000.
- `pc_plus4` = `pc`+4 at all times, including during reset.
- `pc_src`/`jump`/`jr`/`jr_target` are ignored outside EXEC.
- `imem_ack` is ignored outside FETCH; a stray ack in IDLE/EXEC has no effect.
- `exec_stall` is ignored outside EXEC.
- Reset mid-fetch or mid-execute: any in-flight request is abandoned; the late ack arrives in IDLE and is ignored.
- `inst` is a register, so the controller sees a glitch-free instruction for the entire EXEC phase.

Decomposition:
- Shared package:
  - WORD_WIDTH
  - state encoding (IDLE=2'd0, FETCH=2'd1, EXEC=2'd2)
  - NOP_INST=32'h0
  - opcode field positions, shared with the controller
- One natural sub-module: `next_pc_logic`, purely combinational, with inputs pc_plus4, inst, pc_src, jump, jr, jr_target and output next_pc. The FSM and registers stay in `fetch_unit`.

Test Plan:
- Reset then release, memory acks after 3 cycles with 32'h2008_0005 (addi) -> `imem_req` rises 1 cycle after release with addr 0; `inst_valid` pulses 1 cycle; `pc`=4; `retired_count`=1.
- beq at `pc`=32'h10, imm=16'hFFFC, `pc_src`=1 -> next fetch addr 32'h04; same with `pc_src`=0 -> 32'h14.
- j at `pc`=32'h1000_0000, inst=32'h0800_0040 -> next fetch addr 32'h1000_0100; with `jump`=1 and `jr`=1 and `jr_target`=32'h40 together -> 32'h40.
- `exec_stall` high for 4 cycles in EXEC -> `inst_valid` stays 1 for 5 cycles; `pc`/`inst` stable; `retired_count` increments once.
- `pc`=32'hFFFF_FFFC sequential -> next fetch addr 32'h0; `retired_count`=32'hFFFF_FFFF then retire -> 0.
- `nrst` asserted during FETCH with ack arriving the cycle after release -> ack ignored; `pc`=RESET_PC; a fresh request is issued from FETCH.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, FSM encoding, NOP and MIPS field positions.
// Field positions are also used by the main controller when decoding inst.
package fetch_unit_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [WORD_WIDTH-1:0] NOP_INST = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  // Sign-extended, word-scaled branch displacement relative to pc+4.
  function automatic logic [WORD_WIDTH-1:0] branch_offset(input logic [WORD_WIDTH-1:0] inst);
    return {{14{inst[IMM_MSB]}}, inst[IMM_MSB:IMM_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection for the executing instruction.
// Priority jr > jump > taken branch > sequential; all sums wrap modulo 2^32.
module next_pc_logic (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] inst,
  input  logic        pc_src,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);
  import fetch_unit_pkg::*;

  logic [WORD_WIDTH-1:0] jump_target;
  logic [WORD_WIDTH-1:0] branch_target;
  logic                  unused_opcode;

  assign jump_target   = {pc_plus4[31:28], inst[TARGET_MSB:TARGET_LSB], 2'b00};
  assign branch_target = pc_plus4 + branch_offset(inst);
  assign unused_opcode = ^inst[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (pc_src) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake, holds inst for execute.
// At least 2 cycles per instruction; waits in FETCH for ack and in EXEC while exec_stall is high.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] pc_plus4,
  input  logic                  pc_src,
  input  logic                  jump,
  input  logic                  jr,
  input  logic [WORD_WIDTH-1:0] jr_target,
  input  logic                  exec_stall,
  output logic [WORD_WIDTH-1:0] retired_count
);
  import fetch_unit_pkg::*;

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic                  inst_load;
  logic                  retire;
  logic [WORD_WIDTH-1:0] next_pc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + WORD_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    inst_load  = 1'b0;
    retire     = 1'b0;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          inst_load = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        inst_valid = 1'b1;
        if (!exec_stall) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control inputs only reach architectural state through retire, so they are inert outside EXEC.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pc            <= RESET_PC;
      inst          <= NOP_INST;
      retired_count <= '0;
    end else begin
      if (inst_load) begin
        inst <= imem_rdata;
      end
      if (retire) begin
        pc            <= next_pc;
        retired_count <= retired_count + WORD_WIDTH'(1);
      end
    end
  end

  next_pc_logic u_next_pc (
    .pc_plus4  (pc_plus4),
    .inst      (inst),
    .pc_src    (pc_src),
    .jump      (jump),
    .jr        (jr),
    .jr_target (jr_target),
    .next_pc   (next_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, handshake timing, next-PC selection, stall and wrap cases.
module tb_fetch_unit;

  logic        clk;
  logic        nrst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  logic        exec_stall;
  logic [31:0] retired_count;

  int n_asserts = 0;
  int n_fail    = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .WORD_WIDTH(32)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_src        (pc_src),
    .jump          (jump),
    .jr            (jr),
    .jr_target     (jr_target),
    .exec_stall    (exec_stall),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Presents a one-cycle ack in FETCH; returns with the DUT in EXEC.
  task automatic do_fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Retires the current EXEC instruction with the given controller outputs.
  task automatic do_exec(input logic s, input logic j, input logic r, input logic [31:0] tgt);
    pc_src    = s;
    jump      = j;
    jr        = r;
    jr_target = tgt;
    tick();
    pc_src    = 1'b0;
    jump      = 1'b0;
    jr        = 1'b0;
    jr_target = 32'h0;
  endtask

  initial begin
    nrst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    pc_src = 1'b0; jump = 1'b0; jr = 1'b0; jr_target = 32'h0; exec_stall = 1'b0;
    tick();
    tick();
    chk("rst_req",      {31'b0, imem_req},   32'd0);
    chk("rst_valid",    {31'b0, inst_valid}, 32'd0);
    chk("rst_pc",       pc,                  32'h0);
    chk("rst_inst",     inst,                32'h0);
    chk("rst_count",    retired_count,       32'h0);
    chk("rst_pc_plus4", pc_plus4,            32'h4);

    // First fetch: request one cycle after release, ack after 3 FETCH cycles.
    nrst = 1'b1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("first_req",  {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr,         32'h0);
    tick();
    tick();
    chk("wait_req",   {31'b0, imem_req},   32'd1);
    chk("wait_valid", {31'b0, inst_valid}, 32'd0);
    chk("wait_inst",  inst,                32'h0);
    do_fetch(32'h2008_0005);
    chk("addi_valid", {31'b0, inst_valid}, 32'd1);
    chk("addi_req",   {31'b0, imem_req},   32'd0);
    chk("addi_inst",  inst,                32'h2008_0005);
    do_exec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("addi_valid_drop", {31'b0, inst_valid}, 32'd0);
    chk("addi_pc",         pc,                  32'h4);
    chk("addi_count",      retired_count,       32'd1);
    chk("addi_next_addr",  imem_addr,           32'h4);

    // Taken and not-taken beq at 0x10 with imm 0xFFFC.
    do_fetch(32'h0000_0008);
    do_exec(1'b0, 1'b0, 1'b1, 32'h10);
    chk("jr_addr", imem_addr, 32'h10);
    do_fetch(32'h1000_FFFC);
    chk("beq_pc_plus4", pc_plus4, 32'h14);
    do_exec(1'b1, 1'b0, 1'b0, 32'h0);
    chk("beq_taken_addr", imem_addr,     32'h4);
    chk("beq_taken_cnt",  retired_count, 32'd3);
    do_fetch(32'h0000_0008);
    do_exec(1'b0, 1'b0, 1'b1, 32'h10);
    do_fetch(32'h1000_FFFC);
    do_exec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("beq_nt_addr", imem_addr, 32'h14);

    // j within the 0x1 region, then jr overriding jump and pc_src.
    do_fetch(32'h0000_0008);
    do_exec(1'b0, 1'b0, 1'b1, 32'h1000_0000);
    do_fetch(32'h0800_0040);
    do_exec(1'b0, 1'b1, 1'b0, 32'h0);
    chk("j_addr", imem_addr, 32'h1000_0100);
    do_fetch(32'h0800_0040);
    do_exec(1'b1, 1'b1, 1'b1, 32'h40);
    chk("prio_addr",  imem_addr,     32'h40);
    chk("prio_count", retired_count, 32'd8);

    // Four stall cycles with a stray ack: five EXEC cycles, one retirement.
    do_fetch(32'h2008_0005);
    exec_stall = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_valid_%0d", i), {31'b0, inst_valid}, 32'd1);
      chk($sformatf("stall_pc_%0d", i),    pc,                  32'h40);
      chk($sformatf("stall_inst_%0d", i),  inst,                32'h2008_0005);
      chk($sformatf("stall_cnt_%0d", i),   retired_count,       32'd8);
      tick();
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    exec_stall = 1'b0;
    chk("stall_valid_5th", {31'b0, inst_valid}, 32'd1);
    chk("stall_inst_end",  inst,                32'h2008_0005);
    tick();
    chk("stall_valid_end", {31'b0, inst_valid}, 32'd0);
    chk("stall_count",     retired_count,       32'd9);
    chk("stall_pc",        pc,                  32'h44);

    // Controller outputs in FETCH must not move the PC.
    jr = 1'b1; jump = 1'b1; pc_src = 1'b1; jr_target = 32'h80;
    tick();
    chk("fetch_ignore_pc", pc, 32'h44);
    jr = 1'b0; jump = 1'b0; pc_src = 1'b0; jr_target = 32'h0;

    // Sequential wrap from the top of the address space.
    do_fetch(32'h0000_0008);
    do_exec(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc",       pc,       32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    do_fetch(32'h0000_0000);
    do_exec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr",  imem_addr,     32'h0);
    chk("wrap_count", retired_count, 32'd11);

    // Reset mid-fetch; a late ack right after release lands in IDLE.
    do_fetch(32'h0000_0008);
    do_exec(1'b0, 1'b0, 1'b1, 32'h80);
    chk("pre_rst_addr", imem_addr, 32'h80);
    nrst = 1'b0;
    tick();
    chk("midrst_req",   {31'b0, imem_req}, 32'd0);
    chk("midrst_pc",    pc,                32'h0);
    chk("midrst_count", retired_count,     32'd0);
    nrst       = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("late_ack_req",   {31'b0, imem_req},   32'd1);
    chk("late_ack_valid", {31'b0, inst_valid}, 32'd0);
    chk("late_ack_inst",  inst,                32'h0);
    chk("late_ack_addr",  imem_addr,           32'h0);
    tick();
    chk("late_ack_still_fetch", {31'b0, inst_valid}, 32'd0);
    do_fetch(32'h2008_0005);
    do_exec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_rst_pc",    pc,            32'h4);
    chk("post_rst_count", retired_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
